// File: rtl/count_chk_pkg.sv
// Shared types, defaults and the mod-12 step function used by the counter checker.
package count_chk_pkg;

  localparam int unsigned MOD_DEF    = 12;
  localparam int unsigned WIDTH_DEF  = 4;
  localparam int unsigned ERR_W_DEF  = 8;
  localparam int unsigned RELOCK_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] count_t;

  typedef enum logic {LOCKED, LOST} chk_state_t;

  // Wraps at the modulus for legal values; illegal values just move by one mod 2^WIDTH.
  function automatic count_t step(input count_t v, input logic mode);
    if (mode) begin
      return (v == count_t'(MOD_DEF - 1)) ? '0 : v + count_t'(1);
    end else begin
      return (v == '0) ? count_t'(MOD_DEF - 1) : v - count_t'(1);
    end
  endfunction

endpackage

// File: rtl/mod12_count_checker.sv
// Snoops a mod-12 counter's controls and output, runs a reference model and
// flags divergence; drops to LOST on error and re-locks on a legal load or a run of consistent cycles.
module mod12_count_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned MOD        = MOD_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ERR_W      = ERR_W_DEF,
  parameter int unsigned RELOCK_CNT = RELOCK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] exp_count,
  output logic             locked,
  output logic             err_pulse,
  output logic             bad_load,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned   RC_W     = $clog2(RELOCK_CNT + 1);
  localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MOD);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RELOCK_CNT - 1);

  chk_state_t       state, state_nxt;
  logic [RC_W-1:0]  relock_cnt, relock_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic             mismatch_c;
  logic             bad_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, model update and relock tracking
  always_comb begin
    state_nxt  = state;
    relock_nxt = relock_cnt;
    exp_nxt    = exp_count;
    mismatch_c = 1'b0;
    bad_c      = load && (data_in >= MOD_W);
    case (state)
      LOCKED: begin
        mismatch_c = (count_in != exp_count);
        exp_nxt    = load ? data_in : step(exp_count, mode);
        relock_nxt = '0;
        if (mismatch_c || bad_c) begin
          state_nxt = LOST;
        end
      end
      LOST: begin
        // Follow the observed counter so a consistent run can re-lock us.
        exp_nxt = load ? data_in : step(count_in, mode);
        if (bad_c) begin
          relock_nxt = '0;
        end else if (load) begin
          state_nxt  = LOCKED;
          relock_nxt = '0;
        end else if (count_in == exp_count) begin
          if (relock_cnt == RC_LAST) begin
            state_nxt  = LOCKED;
            relock_nxt = '0;
          end else begin
            relock_nxt = relock_cnt + RC_W'(1);
          end
        end else begin
          relock_nxt = '0;
        end
      end
      default: state_nxt = LOCKED;
    endcase
  end

  // Registered model, flags and saturating error counter
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_count  <= '0;
      relock_cnt <= '0;
      locked     <= 1'b1;
      err_pulse  <= 1'b0;
      bad_load   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      exp_count  <= exp_nxt;
      relock_cnt <= relock_nxt;
      locked     <= (state_nxt == LOCKED);
      err_pulse  <= mismatch_c;
      bad_load   <= bad_c;
      if (mismatch_c) begin
        err_sticky <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule
